// File: rtl/regread_requester.sv
// Decoder-side requester for the register bank's toggle-triggered read port.
// Optional macro REGRD_PC_SHORTCUT_EN adds pc_in and serves r15 operands from it.
module regread_requester #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WAIT    = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [11:0]   req_addr,
  input  logic [2:0]    req_use,
  output logic          trig_out,
  output logic [3:0]    addr_out,
  input  logic          rdy_in,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] op_n,
  output logic [DW-1:0] op_m,
  output logic [DW-1:0] op_s,
`ifdef REGRD_PC_SHORTCUT_EN
  input  logic [DW-1:0] pc_in,
`endif
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PICK, WAIT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rdy_sync;
  logic [11:0]            addr_q;
  logic [2:0]             mask;
  logic [CW-1:0]          cnt;

  logic [1:0]             pick_idx;
  logic [3:0]             pick_addr;
  logic [2:0]             mask_left;
  logic                   rdy_ok;
  logic                   tmo;
  logic                   pc_hit;
  logic                   cap_en;
  logic [DW-1:0]          cap_data;

  assign rdy_sync = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], rdy_in};
  end

  // Descending scan so the lowest set bit (rn first) wins.
  always_comb begin
    pick_idx = 2'd0;
    for (int unsigned i = 3; i > 0; i--) begin
      if (mask[i-1]) pick_idx = 2'(i - 1);
    end
    pick_addr = addr_q[{pick_idx, 2'b00} +: 4];
    mask_left = mask & ~(3'b001 << pick_idx);
    rdy_ok    = rdy_sync && (cnt >= CW'(MIN_WAIT));
    tmo       = cnt >= CW'(TIMEOUT);
    pc_hit    = 1'b0;
`ifdef REGRD_PC_SHORTCUT_EN
    pc_hit    = (pick_addr == 4'hF);
`endif
    cap_en    = 1'b0;
    cap_data  = '0;
    if (state == WAIT && (rdy_ok || tmo)) begin
      cap_en   = 1'b1;
      cap_data = rdy_ok ? data_in : '0;
    end
`ifdef REGRD_PC_SHORTCUT_EN
    if (state == PICK && mask != 3'b000 && pc_hit) begin
      cap_en   = 1'b1;
      cap_data = pc_in;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      trig_out  <= 1'b0;
      addr_out  <= '0;
      out_valid <= 1'b0;
      op_n      <= '0;
      op_m      <= '0;
      op_s      <= '0;
      err       <= 1'b0;
      addr_q    <= '0;
      mask      <= '0;
      cnt       <= '0;
    end else begin
      if (cap_en) begin
        case (pick_idx)
          2'd0:    op_n <= cap_data;
          2'd1:    op_m <= cap_data;
          default: op_s <= cap_data;
        endcase
      end
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            mask      <= req_use;
            req_ready <= 1'b0;
            op_n      <= '0;
            op_m      <= '0;
            op_s      <= '0;
            state     <= PICK;
          end
        end
        PICK: begin
          if (mask == 3'b000) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (pc_hit) begin
            mask <= mask_left;
            if (mask_left == 3'b000) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else begin
            addr_out <= pick_addr;
            trig_out <= ~trig_out;
            cnt      <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (rdy_ok || tmo) begin
            if (!rdy_ok) err <= 1'b1;
            mask <= mask_left;
            if (mask_left == 3'b000) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= PICK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regread_requester.sv
// Scoreboard bench for regread_requester with a behavioural register bank.
module tb_regread_requester;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [11:0]   req_addr;
  logic [2:0]    req_use;
  logic          trig_out;
  logic [3:0]    addr_out;
  logic          rdy_in;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] op_n, op_m, op_s;
  logic          err;

  regread_requester #(.DW(DW), .SYNC_STAGES(2), .MIN_WAIT(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_use(req_use), .trig_out(trig_out), .addr_out(addr_out),
    .rdy_in(rdy_in), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .op_n(op_n), .op_m(op_m), .op_s(op_s), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] n;
    logic [DW-1:0] m;
    logic [DW-1:0] s;
    logic          e;
  } exp_t;

  exp_t          sb[$];
  int            compared   = 0;
  int            mismatched = 0;
  int            edges      = 0;
  logic          trig_prev  = 1'b0;
  int            mode       = 0;  // 0: 3-cycle bank, 1: ready held high, 2: never answers
  logic [DW-1:0] mem [16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (trig_out !== trig_prev) edges++;
    trig_prev = trig_out;
  end

  always begin
    @(trig_out);
    if (mode == 1) begin
      #1 data_in = mem[addr_out];
    end else if (mode == 2) begin
      rdy_in = 1'b0;
    end else begin
      rdy_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      data_in = mem[addr_out];
      rdy_in  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("op_n", op_n, e.n);
        check("op_m", op_m, e.m);
        check("op_s", op_s, e.s);
        check("err", {31'd0, err}, {31'd0, e.e});
      end
    end
  end

  task automatic issue(input logic [11:0] a, input logic [2:0] u, input exp_t e,
                       input bit push, input bit wait_done, output int lat);
    int n;
    n   = 0;
    lat = 0;
    @(negedge clk);
    req_addr  = a;
    req_use   = u;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) sb.push_back(e);
    #1 req_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (!out_valid && n < 300) begin
        @(posedge clk);
        #1 n++;
      end
      if (!out_valid) check("done_timeout", 32'd0, 32'd1);
      lat = n;
    end
  endtask

  initial begin
    int lat;
    exp_t e;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    mem[2] = 32'd3; mem[7] = 32'd8; mem[4] = 32'd5;
    mem[9] = 32'hAA; mem[1] = 32'h11; mem[5] = 32'h55;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_use = '0;
    rdy_in = 1'b1; data_in = '0; out_ready = 1'b1;

    #3;
    check("rst_trig", {31'd0, trig_out}, 32'd0);
    check("rst_addr", {28'd0, addr_out}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("req_ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 check("req_ready_after_edge", {31'd0, req_ready}, 32'd1);

    // Two operands via the 3-cycle bank
    edges = 0;
    e = '{n: 32'd3, m: 32'd8, s: 32'd0, e: 1'b0};
    issue(12'h072, 3'b011, e, 1'b1, 1'b1, lat);
    check("t1_trig_edges", edges, 32'd2);

    // Empty mask
    edges = 0;
    e = '{n: 32'd0, m: 32'd0, s: 32'd0, e: 1'b0};
    issue(12'h072, 3'b000, e, 1'b1, 1'b1, lat);
    check("t2_latency", lat, 32'd1);
    check("t2_trig_edges", edges, 32'd0);

    // Ready held high: MIN_WAIT alone gates completion
    mode = 1; rdy_in = 1'b1;
    repeat (3) @(posedge clk);
    edges = 0;
    e = '{n: 32'h55, m: 32'h11, s: 32'hAA, e: 1'b0};
    issue(12'h915, 3'b111, e, 1'b1, 1'b1, lat);
    check("t3_latency", lat, 32'd12);
    check("t3_trig_edges", edges, 32'd3);

    // Bank never answers
    mode = 2;
    e = '{n: 32'd0, m: 32'd0, s: 32'd0, e: 1'b1};
    issue(12'h003, 3'b001, e, 1'b1, 1'b1, lat);
    check("t4_err", {31'd0, err}, 32'd1);

    // Back-pressure in DONE
    mode = 0;
    @(posedge clk); #1 out_ready = 1'b0;
    e = '{n: 32'd0, m: 32'd3, s: 32'd0, e: 1'b1};
    issue(12'h020, 3'b010, e, 1'b1, 1'b1, lat);
    edges = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_op_m", op_m, 32'd3);
      check("t5_hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("t5_stall_trig_edges", edges, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    e = '{n: 32'd0, m: 32'd0, s: 32'd8, e: 1'b1};
    issue(12'h700, 3'b100, e, 1'b1, 1'b1, lat);

    // Reset in the middle of WAIT
    mode = 2;
    issue(12'h001, 3'b001, e, 1'b0, 1'b0, lat);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_trig", {31'd0, trig_out}, 32'd0);
    check("mid_rst_addr", {28'd0, addr_out}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_op_s", op_s, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    e = '{n: 32'd5, m: 32'd0, s: 32'd0, e: 1'b0};
    issue(12'h004, 3'b001, e, 1'b1, 1'b1, lat);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
